// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrates, executes one op at a time, holds result until accepted.
// Define ALU_ARBITER_FIXED_PRI_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    input  logic [5:0]     req_op,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [N-1:0]   rsp_y,
    output logic           rsp_ovf,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_DEC = 3'b010,
        OP_INC = 3'b011,
        OP_NOT = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } op_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] a_q, b_q, y_q;
    op_t          op_q;
    logic         owner_q;
    logic         ovf_q;

    logic         pri_sel;
    logic         grant_any;
    logic         grant_idx;

    logic [N:0]   sum_w, diff_w;
    logic [N-1:0] alu_y;
    logic         alu_ovf;

`ifdef ALU_ARBITER_FIXED_PRI_EN
    assign pri_sel = 1'b0;
`else
    logic rr_q;

    // Pointer names the requester that wins the next contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else if (grant_any) begin
            rr_q <= ~grant_idx;
        end
    end

    assign pri_sel = rr_q;
`endif

    // Grants exist only in IDLE and never while reset is held, so req_ready reads 0 under reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        grant_any = 1'b0;
        grant_idx = 1'b0;
        if (rst_n && state_q == IDLE) begin
            unique case (req_valid)
                2'b01:   begin grant_any = 1'b1; grant_idx = 1'b0;    end
                2'b10:   begin grant_any = 1'b1; grant_idx = 1'b1;    end
                2'b11:   begin grant_any = 1'b1; grant_idx = pri_sel; end
                default: begin grant_any = 1'b0; grant_idx = 1'b0;    end
            endcase
        end
    end

    assign req_ready = grant_any ? (2'b01 << grant_idx) : 2'b00;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Carry and borrow both come from bit N of a zero-extended (N+1)-bit result.
    always_comb begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q};
        diff_w  = {1'b0, a_q} - {1'b0, b_q};
        alu_y   = '0;
        alu_ovf = 1'b0;
        unique case (op_q)
            OP_ADD:  begin alu_y = sum_w[N-1:0];  alu_ovf = sum_w[N];  end
            OP_SUB:  begin alu_y = diff_w[N-1:0]; alu_ovf = diff_w[N]; end
            OP_DEC:  alu_y = a_q - ONE;
            OP_INC:  alu_y = a_q + ONE;
            OP_NOT:  alu_y = ~a_q;
            OP_AND:  alu_y = a_q & b_q;
            OP_OR:   alu_y = a_q | b_q;
            OP_XOR:  alu_y = a_q ^ b_q;
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            owner_q <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
            state_q <= state_d;
            if (grant_any) begin
                a_q     <= req_a[grant_idx*N +: N];
                b_q     <= req_b[grant_idx*N +: N];
                op_q    <= op_t'(req_op[grant_idx*3 +: 3]);
                owner_q <= grant_idx;
            end
            if (state_q == EXEC) begin
                y_q   <= alu_y;
                ovf_q <= alu_ovf;
            end
        end
    end

    assign rsp_valid = (state_q == RESP) ? (2'b01 << owner_q) : 2'b00;
    assign rsp_y     = y_q;
    assign rsp_ovf   = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grants checked at issue, results scoreboarded and checked at handshake.
module tb_alu_arbiter;

    localparam int N = 4;
`ifdef ALU_ARBITER_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [5:0]     req_op;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [N-1:0]   rsp_y;
    logic           rsp_ovf;
    logic           busy;

    typedef struct {
        int           owner;
        logic [N-1:0] y;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rr_exp = 0;

    alu_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic done in plain integers, then wrapped to N bits.
    function automatic exp_t model(input int owner, input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic [2:0] op);
        exp_t e;
        int   ia = int'(a);
        int   ib = int'(b);
        int   m  = 1 << N;
        e.owner = owner;
        e.ovf   = 1'b0;
        case (op)
            3'd0: begin e.y = N'((ia + ib) % m); e.ovf = (ia + ib) >= m; end
            3'd1: begin e.y = N'((ia - ib + m) % m); e.ovf = ia < ib; end
            3'd2: e.y = N'((ia + m - 1) % m);
            3'd3: e.y = N'((ia + 1) % m);
            3'd4: e.y = ~a;
            3'd5: e.y = a & b;
            3'd6: e.y = a | b;
            default: e.y = a ^ b;
        endcase
        return e;
    endfunction

    // Called just after a falling edge; drives a request and checks the grant in this cycle.
    task automatic issue(input logic [1:0] valid,
                         input logic [N-1:0] a0, input logic [N-1:0] b0, input logic [2:0] op0,
                         input logic [N-1:0] a1, input logic [N-1:0] b1, input logic [2:0] op1);
        int g;
        bit ok = 1'b0;
        req_valid = valid;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_op    = {op1, op0};
        if (valid == 2'b11) g = FIXED ? 0 : rr_exp;
        else                g = valid[1] ? 1 : 0;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (req_ready != 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check("grant_seen", 32'(ok), 32'd1);
        check("grant_onehot", 32'(req_ready), 32'(2'b01 << g));
        check("grant_busy", 32'(busy), 32'd0);
        if (ok) sb.push_back(g == 0 ? model(0, a0, b0, op0) : model(1, a1, b1, op1));
        rr_exp = 1 - g;
    endtask

    // Follows the op through EXEC and RESP, stalling the handshake for 'stall' cycles.
    task automatic collect(input int stall, input bit keep_valid);
        exp_t e;
        @(negedge clk);
        if (!keep_valid) req_valid = 2'b00;
        req_a  = (2*N)'($urandom);
        req_b  = (2*N)'($urandom);
        req_op = 6'($urandom);
        #1;
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb[0];
        @(negedge clk); #1;
        check("latency_rsp_valid", 32'(rsp_valid), 32'(2'b01 << e.owner));
        for (int i = 0; i < stall; i++) begin
            rsp_ready = (e.owner == 1) ? 2'b01 : 2'b10;
            #1;
            check("stall_rsp_valid", 32'(rsp_valid), 32'(2'b01 << e.owner));
            check("stall_rsp_y", 32'(rsp_y), 32'(e.y));
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            @(negedge clk); #1;
        end
        rsp_ready = (e.owner == 1) ? 2'b10 : 2'b01;
        #1;
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(2'b01 << e.owner));
        check("rsp_y", 32'(rsp_y), 32'(e.y));
        check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
        check("handshake_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 2'b00;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Add with carry, subtract with borrow, wrap-around decrement/increment.
        issue(2'b01, 4'd9, 4'd8, 3'b000, 4'd0, 4'd0, 3'b000);  collect(0, 1'b0);
        issue(2'b10, 4'd0, 4'd0, 3'b000, 4'd3, 4'd5, 3'b001);  collect(0, 1'b0);
        issue(2'b10, 4'd7, 4'd7, 3'b000, 4'd0, 4'd6, 3'b010);  collect(0, 1'b0);
        issue(2'b01, 4'd15, 4'd2, 3'b011, 4'd0, 4'd0, 3'b000); collect(0, 1'b0);
        issue(2'b01, 4'd6, 4'd9, 3'b000, 4'd0, 4'd0, 3'b000);  collect(0, 1'b0);
        issue(2'b10, 4'd0, 4'd0, 3'b000, 4'd9, 4'd4, 3'b001);  collect(0, 1'b0);
        issue(2'b01, 4'd10, 4'd0, 3'b100, 4'd0, 4'd0, 3'b000); collect(0, 1'b0);
        issue(2'b10, 4'd0, 4'd0, 3'b000, 4'd12, 4'd10, 3'b101); collect(0, 1'b0);
        issue(2'b01, 4'd12, 4'd3, 3'b110, 4'd0, 4'd0, 3'b000); collect(0, 1'b0);

        // Held response with non-owner rsp_ready asserted meanwhile.
        issue(2'b01, 4'd5, 4'd3, 3'b111, 4'd0, 4'd0, 3'b000);  collect(5, 1'b0);

        // Reset during EXEC discards the op.
        issue(2'b01, 4'd3, 4'd4, 3'b000, 4'd0, 4'd0, 3'b000);
        @(negedge clk);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_y", 32'(rsp_y), 32'd0);
        check("midrst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        sb.delete();
        rr_exp    = 0;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("postrst_busy", 32'(busy), 32'd0);
        end

        // Continuous contention: round-robin alternates, fixed priority always picks 0.
        for (int i = 0; i < 4; i++) begin
            issue(2'b11, 4'd1, 4'd2, 3'b000, 4'd14, 4'd3, 3'b000);
            collect(0, i < 3);
        end

        issue(2'b10, 4'd0, 4'd0, 3'b000, 4'd8, 4'd8, 3'b000);  collect(1, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 4: operand/result width in bits.
REQ-002 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port req_valid, input, 2: per-requester request valid; bit i is requester i.
REQ-005 Port req_ready, output, 2: per-requester grant/accept strobe.
REQ-006 Port req_a, input, 2*N: operand A; bits [i*N +: N] belong to requester i.
REQ-007 Port req_b, input, 2*N: operand B, packed as req_a.
REQ-008 Port req_op, input, 6: 3-bit opcode; bits [i*3 +: 3] belong to requester i.
REQ-009 Port rsp_valid, output, 2: one-hot result valid, bit set for the owning requester.
REQ-010 Port rsp_ready, input, 2: per-requester result accept.
REQ-011 Port rsp_y, output, N: registered result.
REQ-012 Port rsp_ovf, output, 1: registered overflow flag.
REQ-013 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; a single operation is in flight at a time.
REQ-015 IDLE: if any req_valid is high, grant exactly one requester; set req_ready[g]=1 combinationally in that cycle only; register A, B, op and owner g; go to EXEC.
REQ-016 req_ready SHALL be 0 in EXEC and RESP; never more than one req_ready bit high.
REQ-017 Arbitration: round-robin; after serving requester g, requester 1-g has priority on the next contention; a lone requester is always granted.
REQ-018 EXEC (one cycle): compute and register rsp_y/rsp_ovf; go to RESP.
REQ-019 Opcodes: 000 A+B, ovf=carry-out; 001 A-B, ovf=bit N of (N+1)-bit difference (1 when A<B); 010 A-1; 011 A+1; 100 ~A; 101 A&B; 110 A|B; 111 A^B; ovf=0 for 010-111.
REQ-020 All results are mod 2^N; 010 with A=0 yields all ones, 011 with A=all ones yields 0, ovf=0 in both.
REQ-021 RESP: rsp_valid[owner]=1; rsp_y/rsp_ovf held stable until rsp_ready[owner]=1, then return to IDLE.
REQ-022 rsp_ready of the non-owner bit is ignored.
REQ-023 Latency: grant in cycle t, rsp_valid high from cycle t+2; minimum issue interval 3 cycles.
REQ-024 A new grant may occur in the IDLE cycle immediately following the response handshake, not in the handshake cycle itself.
REQ-025 Operands/opcode changing after grant SHALL NOT affect the in-flight result.

Reset
REQ-026 rst_n low: state=IDLE, req_ready=0, rsp_valid=0, rsp_y=0, rsp_ovf=0, busy=0, round-robin pointer favours requester 0.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no response issued.

Configuration
REQ-028 Macro ALU_ARBITER_FIXED_PRI_EN: when defined, arbitration is fixed priority (requester 0 always wins contention) and the round-robin pointer is not implemented; when undefined, REQ-017 round-robin applies.

Verification
REQ-029 N=4, req0 A=9 B=8 op=000, rsp_ready=1 -> rsp_valid=01 two cycles after grant, rsp_y=1, rsp_ovf=1.
REQ-030 req1 A=3 B=5 op=001 -> rsp_valid=10, rsp_y=14, rsp_ovf=1; then op=010 with A=0 -> rsp_y=15, rsp_ovf=0.
REQ-031 Both requesters valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1 (round-robin build); with ALU_ARBITER_FIXED_PRI_EN, grants are 0,0,0,0.
REQ-032 req0 op=111 A=5 B=3, rsp_ready=0 for 5 cycles -> rsp_valid=01 and rsp_y=6 held stable, req_ready=00, busy=1 throughout; response consumed on rsp_ready[0]=1.
REQ-033 Change req_a/req_b after grant -> result reflects the granted values only.
REQ-034 Drop rst_n during EXEC -> all outputs 0 asynchronously, no rsp_valid after release, next request served normally.
